// File: rtl/gremlin_hit_detector_pkg.sv
// Shared definitions for the gremlin hit detector.
// Contents:
//   - gremlin sprite size
//   - gremlin descriptor layout
//   - FSM state encoding
//   - saturating BCD score increment
package gremlin_hit_detector_pkg;

   localparam int unsigned GremW = 16;
   localparam int unsigned GremH = 32;
   localparam int unsigned PosW  = 11;
   localparam int unsigned DescW = 24;
   localparam int unsigned CmpW  = 12;

   // Descriptor layout: bit 23 color, 22:12 xpos, 11:1 ypos, 0 active.
   typedef struct packed {
      logic            color;
      logic [PosW-1:0] xpos;
      logic [PosW-1:0] ypos;
      logic            active;
   } grem_desc_t;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StLatch  = 3'd1,
      StCheck0 = 3'd2,
      StCheck1 = 3'd3,
      StUpdate = 3'd4
   } state_e;

   // Adds inc (0..2) to a 4-digit BCD value; any carry out of the top digit saturates at 9999.
   function automatic logic [15:0] bcd_add_sat(input logic [15:0] bcd, input logic [1:0] inc);
      logic [15:0] res;
      logic [4:0]  sum;
      logic [1:0]  carry;
      res   = '0;
      carry = inc;
      for (int i = 0; i < 4; i++) begin
         sum = {1'b0, bcd[4*i +: 4]} + {3'b000, carry};
         if (sum > 5'd9) begin
            res[4*i +: 4] = 4'(sum - 5'd10);
            carry         = 2'd1;
         end else begin
            res[4*i +: 4] = sum[3:0];
            carry         = 2'd0;
         end
      end
      if (carry != 2'd0) begin
         res = 16'h9999;
      end
      return res;
   endfunction

endpackage

// File: rtl/gremlin_overlap_check.sv
// Combinational bounding-box overlap test between one gremlin and the car.
// Ports:
//   grem_x_i, grem_y_i : gremlin top-left position
//   car_x_i,  car_y_i  : car top-left position
//   overlap_o          : high when the boxes share at least one pixel (touching edges do not count)
module gremlin_overlap_check
   import gremlin_hit_detector_pkg::*;
#(
   parameter int unsigned CAR_W = 16,
   parameter int unsigned CAR_H = 32
) (
   input  logic [PosW-1:0] grem_x_i,
   input  logic [PosW-1:0] grem_y_i,
   input  logic [PosW-1:0] car_x_i,
   input  logic [PosW-1:0] car_y_i,
   output logic            overlap_o
);

   // One extra bit so position + size never wraps.
   logic [CmpW-1:0] gx, gy, cx, cy;

   assign gx = {1'b0, grem_x_i};
   assign gy = {1'b0, grem_y_i};
   assign cx = {1'b0, car_x_i};
   assign cy = {1'b0, car_y_i};

   assign overlap_o = (gx < cx + CmpW'(CAR_W))  &&
                      (cx < gx + CmpW'(GremW))  &&
                      (gy < cy + CmpW'(CAR_H))  &&
                      (cy < gy + CmpW'(GremH));

endmodule

// File: rtl/gremlin_hit_detector.sv
// Once per frame, checks two gremlins against the car and maintains the score.
// Ports:
//   pclk, rst_n        : clock, asynchronous active-low reset
//   vsync_in           : vertical sync; its rising edge starts a detection sequence
//   grem0_in, grem1_in : gremlin descriptors (color, xpos, ypos, active)
//   car_xpos, car_ypos : car top-left position
//   hit_pulse          : one-cycle per-gremlin hit strobe
//   grem_kill          : per-gremlin suppression level
//   score              : 4-digit BCD hit count, saturating at 9999
//   busy               : high while a sequence is in progress
module gremlin_hit_detector
   import gremlin_hit_detector_pkg::*;
#(
   parameter int unsigned CAR_W       = 16,
   parameter int unsigned CAR_H       = 32,
   parameter int unsigned DEAD_FRAMES = 60
) (
   input  logic             pclk,
   input  logic             rst_n,
   input  logic             vsync_in,
   input  logic [DescW-1:0] grem0_in,
   input  logic [DescW-1:0] grem1_in,
   input  logic [PosW-1:0]  car_xpos,
   input  logic [PosW-1:0]  car_ypos,
   output logic [1:0]       hit_pulse,
   output logic [1:0]       grem_kill,
   output logic [15:0]      score,
   output logic             busy
);

   localparam int unsigned CntW = (DEAD_FRAMES > 0) ? $clog2(DEAD_FRAMES + 1) : 1;
   localparam logic [CntW-1:0] DeadLoad = CntW'(DEAD_FRAMES);

   state_e               state_q, state_d;
   logic                 vsync_q;
   logic                 frame_start_q;
   grem_desc_t           grem0_q, grem0_d;
   grem_desc_t           grem1_q, grem1_d;
   logic [PosW-1:0]      car_x_q, car_x_d;
   logic [PosW-1:0]      car_y_q, car_y_d;
   logic [1:0]           hit_q, hit_d;
   logic [1:0]           kill_q, kill_d;
   logic [1:0][CntW-1:0] cnt_q, cnt_d;
   logic [15:0]          score_q, score_d;
   logic [1:0]           overlap;
   logic [1:0]           hit_cnt;

   gremlin_overlap_check #(
      .CAR_W (CAR_W),
      .CAR_H (CAR_H)
   ) u_overlap0 (
      .grem_x_i  (grem0_q.xpos),
      .grem_y_i  (grem0_q.ypos),
      .car_x_i   (car_x_q),
      .car_y_i   (car_y_q),
      .overlap_o (overlap[0])
   );

   gremlin_overlap_check #(
      .CAR_W (CAR_W),
      .CAR_H (CAR_H)
   ) u_overlap1 (
      .grem_x_i  (grem1_q.xpos),
      .grem_y_i  (grem1_q.ypos),
      .car_x_i   (car_x_q),
      .car_y_i   (car_y_q),
      .overlap_o (overlap[1])
   );

   // Color is carried in the descriptor but plays no part in collision.
   logic unused_color;
   assign unused_color = grem0_q.color ^ grem1_q.color;

   assign hit_cnt = {1'b0, hit_q[0]} + {1'b0, hit_q[1]};

   always_comb begin
      state_d = state_q;
      grem0_d = grem0_q;
      grem1_d = grem1_q;
      car_x_d = car_x_q;
      car_y_d = car_y_q;
      hit_d   = hit_q;
      kill_d  = kill_q;
      cnt_d   = cnt_q;
      score_d = score_q;
      unique case (state_q)
         StIdle: begin
            // A frame start arriving in any other state is simply dropped.
            if (frame_start_q) begin
               state_d = StLatch;
            end
         end
         StLatch: begin
            grem0_d = grem_desc_t'(grem0_in);
            grem1_d = grem_desc_t'(grem1_in);
            car_x_d = car_xpos;
            car_y_d = car_ypos;
            hit_d   = 2'b00;
            state_d = StCheck0;
         end
         StCheck0: begin
            hit_d[0] = grem0_q.active & ~kill_q[0] & overlap[0];
            state_d  = StCheck1;
         end
         StCheck1: begin
            hit_d[1] = grem1_q.active & ~kill_q[1] & overlap[1];
            state_d  = StUpdate;
         end
         StUpdate: begin
            for (int n = 0; n < 2; n++) begin
               if (hit_q[n]) begin
                  kill_d[n] = 1'b1;
                  cnt_d[n]  = DeadLoad;
               end else if (cnt_q[n] != '0) begin
                  cnt_d[n] = cnt_q[n] - CntW'(1);
                  if (cnt_q[n] == CntW'(1)) begin
                     kill_d[n] = 1'b0;
                  end
               end
            end
            score_d = bcd_add_sat(score_q, hit_cnt);
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         vsync_q       <= 1'b0;
         frame_start_q <= 1'b0;
         grem0_q       <= '0;
         grem1_q       <= '0;
         car_x_q       <= '0;
         car_y_q       <= '0;
         hit_q         <= '0;
         kill_q        <= '0;
         cnt_q         <= '0;
         score_q       <= '0;
      end else begin
         state_q       <= state_d;
         vsync_q       <= vsync_in;
         frame_start_q <= vsync_in & ~vsync_q;
         grem0_q       <= grem0_d;
         grem1_q       <= grem1_d;
         car_x_q       <= car_x_d;
         car_y_q       <= car_y_d;
         hit_q         <= hit_d;
         kill_q        <= kill_d;
         cnt_q         <= cnt_d;
         score_q       <= score_d;
      end
   end

   assign hit_pulse = (state_q == StUpdate) ? hit_q : 2'b00;
   assign grem_kill = kill_q;
   assign score     = score_q;
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_gremlin_hit_detector.sv
// Self-checking bench: a default instance (60 dead frames) and a fast instance (1 dead frame)
// share all inputs; each is compared every frame against a frame-level behavioural model.
module tb_gremlin_hit_detector;

   localparam int CarW  = 16;
   localparam int CarH  = 32;
   localparam int GremW = 16;
   localparam int GremH = 32;

   logic        pclk;
   logic        rst_n;
   logic        vsync_in;
   logic [23:0] grem0_in, grem1_in;
   logic [10:0] car_xpos, car_ypos;

   logic [1:0]  hp_w [2];
   logic [1:0]  gk_w [2];
   logic [15:0] sc_w [2];
   logic        bz_w [2];

   int n_checks = 0;
   int n_errors = 0;

   int dead_frames [2];
   int m_score [2];
   int m_rem   [2][2];
   bit m_kill  [2][2];
   bit m_hit   [2][2];

   logic [1:0] last_hp [2];
   logic [1:0] last_gk [2];

   gremlin_hit_detector #(
      .CAR_W       (CarW),
      .CAR_H       (CarH),
      .DEAD_FRAMES (60)
   ) u_dut (
      .pclk      (pclk),
      .rst_n     (rst_n),
      .vsync_in  (vsync_in),
      .grem0_in  (grem0_in),
      .grem1_in  (grem1_in),
      .car_xpos  (car_xpos),
      .car_ypos  (car_ypos),
      .hit_pulse (hp_w[0]),
      .grem_kill (gk_w[0]),
      .score     (sc_w[0]),
      .busy      (bz_w[0])
   );

   gremlin_hit_detector #(
      .CAR_W       (CarW),
      .CAR_H       (CarH),
      .DEAD_FRAMES (1)
   ) u_dut_fast (
      .pclk      (pclk),
      .rst_n     (rst_n),
      .vsync_in  (vsync_in),
      .grem0_in  (grem0_in),
      .grem1_in  (grem1_in),
      .car_xpos  (car_xpos),
      .car_ypos  (car_ypos),
      .hit_pulse (hp_w[1]),
      .grem_kill (gk_w[1]),
      .score     (sc_w[1]),
      .busy      (bz_w[1])
   );

   initial begin
      pclk = 1'b0;
      forever #5 pclk = ~pclk;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] mk(input int color, input int x, input int y, input bit act);
      return {1'(color), 11'(x), 11'(y), act};
   endfunction

   function automatic bit boxes_hit(input int gx, input int gy, input int cx, input int cy);
      return (gx < cx + CarW) && (cx < gx + GremW) && (gy < cy + CarH) && (cy < gy + GremH);
   endfunction

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      r[15:12] = 4'((v / 1000) % 10);
      r[11:8]  = 4'((v / 100) % 10);
      r[7:4]   = 4'((v / 10) % 10);
      r[3:0]   = 4'(v % 10);
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_score[i] = 0;
         for (int n = 0; n < 2; n++) begin
            m_rem[i][n]  = 0;
            m_kill[i][n] = 1'b0;
            m_hit[i][n]  = 1'b0;
         end
      end
   endtask

   task automatic model_update();
      for (int i = 0; i < 2; i++) begin
         int hits;
         hits = 0;
         for (int n = 0; n < 2; n++) begin
            if (m_hit[i][n]) begin
               hits++;
               m_kill[i][n] = 1'b1;
               m_rem[i][n]  = dead_frames[i];
            end else if (m_rem[i][n] > 0) begin
               m_rem[i][n]--;
               if (m_rem[i][n] == 0) m_kill[i][n] = 1'b0;
            end
         end
         m_score[i] = (m_score[i] + hits > 9999) ? 9999 : m_score[i] + hits;
      end
   endtask

   task automatic check_all_zero(input string tag);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("%s_hp%0d", tag, i), 32'(hp_w[i]), 32'd0);
         check($sformatf("%s_kill%0d", tag, i), 32'(gk_w[i]), 32'd0);
         check($sformatf("%s_score%0d", tag, i), 32'(sc_w[i]), 32'd0);
         check($sformatf("%s_busy%0d", tag, i), 32'(bz_w[i]), 32'd0);
      end
   endtask

   task automatic reset_dut();
      rst_n    = 1'b0;
      vsync_in = 1'b0;
      grem0_in = '0;
      grem1_in = '0;
      car_xpos = '0;
      car_ypos = '0;
      @(negedge pclk);
      @(negedge pclk);
      check_all_zero("reset");
      model_reset();
      rst_n = 1'b1;
   endtask

   // Called and returns at a negedge. One frame takes six cycles.
   task automatic run_frame(input logic [23:0] g0, input logic [23:0] g1, input int cx,
                            input int cy, input bit glitch, input bit abort);
      logic [23:0] d;
      grem0_in = g0;
      grem1_in = g1;
      car_xpos = 11'(cx);
      car_ypos = 11'(cy);
      vsync_in = 1'b1;
      for (int i = 0; i < 2; i++) begin
         for (int n = 0; n < 2; n++) begin
            d = (n == 0) ? g0 : g1;
            m_hit[i][n] = d[0] && !m_kill[i][n] &&
                          boxes_hit(int'(d[22:12]), int'(d[11:1]), int'(car_xpos), int'(car_ypos));
         end
      end
      @(negedge pclk);
      vsync_in = 1'b0;
      for (int i = 0; i < 2; i++) check($sformatf("busy_pre%0d", i), 32'(bz_w[i]), 32'd0);
      @(negedge pclk);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("busy_run%0d", i), 32'(bz_w[i]), 32'd1);
         check($sformatf("hp_early_a%0d", i), 32'(hp_w[i]), 32'd0);
      end
      if (glitch) vsync_in = 1'b1;
      @(negedge pclk);
      vsync_in = 1'b0;
      for (int i = 0; i < 2; i++) check($sformatf("hp_early_b%0d", i), 32'(hp_w[i]), 32'd0);
      @(negedge pclk);
      if (abort) begin
         rst_n = 1'b0;
         #1;
         check_all_zero("abort");
         model_reset();
         @(negedge pclk);
         rst_n = 1'b1;
         return;
      end
      for (int i = 0; i < 2; i++) check($sformatf("hp_early_c%0d", i), 32'(hp_w[i]), 32'd0);
      @(negedge pclk);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("hit_pulse%0d", i), 32'(hp_w[i]), 32'({m_hit[i][1], m_hit[i][0]}));
         check($sformatf("busy_upd%0d", i), 32'(bz_w[i]), 32'd1);
         last_hp[i] = hp_w[i];
      end
      model_update();
      @(negedge pclk);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("kill%0d", i), 32'(gk_w[i]), 32'({m_kill[i][1], m_kill[i][0]}));
         check($sformatf("score%0d", i), 32'(sc_w[i]), 32'(to_bcd(m_score[i])));
         check($sformatf("busy_post%0d", i), 32'(bz_w[i]), 32'd0);
         check($sformatf("hp_late%0d", i), 32'(hp_w[i]), 32'd0);
         last_gk[i] = gk_w[i];
      end
   endtask

   initial begin
      int cx, cy, gx0, gy0, gx1, gy1, extra;
      bit hitf, dbl;
      logic [23:0] g0, g1;

      dead_frames[0] = 60;
      dead_frames[1] = 1;
      reset_dut();

      // Basic hit on gremlin 0.
      run_frame(mk(0, 200, 300, 1), mk(0, 600, 300, 0), 205, 310, 1'b0, 1'b0);
      check("basic_hp", 32'(last_hp[0]), 32'h1);
      check("basic_kill", 32'(last_gk[0]), 32'h1);
      check("basic_score", 32'(sc_w[0]), 32'h0001);

      // Gremlin 0 stays overlapping; gremlin 1 exercises inactive and edge cases.
      for (int k = 1; k <= 61; k++) begin
         cx = (k == 2) ? 184 : (k == 3) ? 185 : 205;
         run_frame(mk(1, 200, 300, 1), mk(0, 200, 300, k != 1), cx, 310, 1'b0, 1'b0);
         if (k == 1) check("inactive_nohit", 32'(last_hp[0][1]), 32'd0);
         if (k == 2) check("touch_nohit", 32'(last_hp[0][1]), 32'd0);
         if (k == 3) check("adjacent_hit", 32'(last_hp[0]), 32'h2);
         if (k == 59) check("kill_held59", 32'(last_gk[0][0]), 32'd1);
         if (k == 60) begin
            check("kill_clear60", 32'(last_gk[0][0]), 32'd0);
            check("no_hit60", 32'(last_hp[0][0]), 32'd0);
         end
         if (k == 61) check("rehit61", 32'(last_hp[0][0]), 32'd1);
      end

      // Reset during CHECK1, then a normal sequence.
      run_frame(mk(0, 200, 300, 1), mk(0, 600, 300, 1), 205, 310, 1'b0, 1'b1);
      run_frame(mk(0, 200, 300, 1), mk(0, 600, 300, 1), 205, 310, 1'b0, 1'b0);
      check("post_abort_hp", 32'(last_hp[0]), 32'h1);
      check("post_abort_score", 32'(sc_w[0]), 32'h0001);

      // Randomized frames near the car, with occasional vsync edges while busy.
      for (int r = 0; r < 150; r++) begin
         cx  = int'($urandom_range(60, 1980));
         cy  = int'($urandom_range(60, 1980));
         gx0 = cx + int'($urandom_range(0, 48)) - 24;
         gy0 = cy + int'($urandom_range(0, 80)) - 40;
         gx1 = cx + int'($urandom_range(0, 48)) - 24;
         gy1 = cy + int'($urandom_range(0, 80)) - 40;
         g0  = mk(int'($urandom_range(0, 1)), gx0, gy0, $urandom_range(0, 3) != 0);
         g1  = mk(int'($urandom_range(0, 1)), gx1, gy1, $urandom_range(0, 3) != 0);
         run_frame(g0, g1, cx, cy, $urandom_range(0, 3) == 0, 1'b0);
      end

      // Drive the fast instance up to saturation, passing 0009+1, 0099+2 and 9998+2.
      reset_dut();
      extra = 0;
      for (int f = 0; f < 12000 && extra < 4; f++) begin
         hitf = (f % 2) == 0;
         dbl  = hitf && !(m_score[1] < 11 || m_score[1] == 101);
         run_frame(mk(0, 500, 500, hitf), mk(1, 500, 500, dbl), 505, 510, 1'b0, 1'b0);
         if (m_score[1] == 9999) extra++;
      end
      check("sat_final", 32'(sc_w[1]), 32'h9999);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
